sprite_compositor: RTL and testbench

- Display-side consumer of the game state block's object outputs (bird, pipes, score digits, text banners).
- Snapshots those outputs once per frame at vertical blank into shadow registers, then issues the one-cycle `new_frame` tick that drives the game state block.
- Per pixel, decides which layer owns the pixel (background/ground/pipe/bird/digits/text) and emits that layer's sprite-ROM address through a 2-stage pipeline.

---
 rtl/sprite_compositor.sv | 259 +++++++++++++++++++++++++
 tb/tb_sprite_compositor.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// Sprite compositor: latches game-object state at vertical blank, then resolves the
// owning layer and sprite-ROM address for each pixel through a 2-stage pipeline.
// Optional build macro PIXEL_COLLIDE_EN adds the sticky pix_collide output.
module sprite_compositor #(
  parameter int GROUND_X = 104,
  parameter int PIPE_W   = 64,
  parameter int PIPE_GAP = 240,
  parameter int TEXT_X   = 560,
  parameter int TEXT_Y   = 112
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblank_start,
  input  logic        pix_valid,
  input  logic [15:0] pix_x,
  input  logic [15:0] pix_y,
  input  logic [1:0]  bird_status,
  input  logic [15:0] bird_pos_x,
  input  logic [15:0] bird_pos_y,
  input  logic [15:0] pipe1_pos_x,
  input  logic [15:0] pipe1_pos_y,
  input  logic [15:0] pipe2_pos_x,
  input  logic [15:0] pipe2_pos_y,
  input  logic [15:0] pipe3_pos_x,
  input  logic [15:0] pipe3_pos_y,
  input  logic        number_enable,
  input  logic [15:0] number_pos_x,
  input  logic [15:0] number_pos_y,
  input  logic [3:0]  number_num0,
  input  logic [3:0]  number_num1,
  input  logic        logo_enable,
  input  logic        ready_enable,
  input  logic        over_enable,
  output logic        new_frame,
  output logic        out_valid,
  output logic [2:0]  layer,
  output logic [15:0] rom_addr
`ifdef PIXEL_COLLIDE_EN
  ,
  output logic        pix_collide
`endif
);

  localparam logic signed [15:0] GROUND_X_S  = 16'(GROUND_X);
  localparam logic [15:0]        GROUND_LAST = 16'(GROUND_X - 1);
  localparam logic signed [15:0] PIPE_W_S    = 16'(PIPE_W);
  localparam logic [15:0]        PIPE_GAP_V  = 16'(PIPE_GAP);
  localparam logic [15:0]        TEXT_X_V    = 16'(TEXT_X);
  localparam logic [15:0]        TEXT_Y_V    = 16'(TEXT_Y);

  logic [1:0]  bird_status_reg;
  logic [15:0] bird_x_reg, bird_y_reg, number_x_reg, number_y_reg;
  logic [3:0]  num0_reg, num1_reg;
  logic        number_en_reg, logo_en_reg, ready_en_reg, over_en_reg;
  logic        new_frame_reg;

  // Shadows only change at vblank so a frame is drawn from one consistent snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      bird_status_reg <= '0;
      bird_x_reg      <= '0;
      bird_y_reg      <= '0;
      number_x_reg    <= '0;
      number_y_reg    <= '0;
      num0_reg        <= '0;
      num1_reg        <= '0;
      number_en_reg   <= 1'b0;
      logo_en_reg     <= 1'b0;
      ready_en_reg    <= 1'b0;
      over_en_reg     <= 1'b0;
      new_frame_reg   <= 1'b0;
    end else begin
      new_frame_reg <= vblank_start;
      if (vblank_start) begin
        bird_status_reg <= bird_status;
        bird_x_reg      <= bird_pos_x;
        bird_y_reg      <= bird_pos_y;
        number_x_reg    <= number_pos_x;
        number_y_reg    <= number_pos_y;
        num0_reg        <= number_num0;
        num1_reg        <= number_num1;
        number_en_reg   <= number_enable;
        logo_en_reg     <= logo_enable;
        ready_en_reg    <= ready_enable;
        over_en_reg     <= over_enable;
      end
    end
  end

  logic       ground_hit;
  logic [6:0] ground_addr;
  assign ground_hit  = $signed(pix_x) < GROUND_X_S;
  assign ground_addr = GROUND_LAST[6:0] - pix_x[6:0];

  logic [15:0] pipe_x_in [3];
  logic [15:0] pipe_y_in [3];
  logic [2:0]  pipe_hit;
  logic [5:0]  pipe_addr [3];
  assign pipe_x_in[0] = pipe1_pos_x;
  assign pipe_x_in[1] = pipe2_pos_x;
  assign pipe_x_in[2] = pipe3_pos_x;
  assign pipe_y_in[0] = pipe1_pos_y;
  assign pipe_y_in[1] = pipe2_pos_y;
  assign pipe_y_in[2] = pipe3_pos_y;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pipe
      logic [15:0]        x_reg, y_reg;
      logic signed [15:0] dy, gap_lo;

      always_ff @(posedge clk) begin
        if (rst) begin
          x_reg <= '0;
          y_reg <= '0;
        end else if (vblank_start) begin
          x_reg <= pipe_x_in[gi];
          y_reg <= pipe_y_in[gi];
        end
      end

      assign dy     = pix_y - y_reg;
      assign gap_lo = x_reg - PIPE_GAP_V;
      // Solid everywhere along x except the flight gap just below the pipe origin.
      assign pipe_hit[gi]  = !dy[15] && (dy < PIPE_W_S) && !ground_hit &&
                             (($signed(pix_x) < gap_lo) || ($signed(pix_x) >= $signed(x_reg)));
      assign pipe_addr[gi] = dy[5:0];
    end
  endgenerate

  logic [5:0] pipe_sel_addr;
  always_comb begin
    pipe_sel_addr = pipe_addr[2];
    if (pipe_hit[0])      pipe_sel_addr = pipe_addr[0];
    else if (pipe_hit[1]) pipe_sel_addr = pipe_addr[1];
  end

  logic [15:0] bird_dx, bird_dy;
  logic [1:0]  bird_frame;
  logic        bird_hit;
  assign bird_dx    = pix_x - bird_x_reg;
  assign bird_dy    = pix_y - bird_y_reg;
  assign bird_frame = (bird_status_reg == 2'd3) ? 2'd1 : bird_status_reg;
  assign bird_hit   = (bird_dx[15:5] == '0) && (bird_dy[15:5] == '0);

  logic [15:0] num_dx, num_dy;
  logic [3:0]  digit_val;
  logic        digit_hit;
  assign num_dx    = pix_x - number_x_reg;
  assign num_dy    = pix_y - number_y_reg;
  assign digit_val = num_dy[5] ? num0_reg : num1_reg;
  assign digit_hit = number_en_reg && (num_dx[15:6] == '0) && (num_dx[5:4] != 2'b11) &&
                     (num_dy[15:6] == '0) && (digit_val <= 4'd9);

  logic [15:0] text_dx, text_dy;
  logic [1:0]  text_sel;
  logic        text_hit;
  assign text_dx  = pix_x - TEXT_X_V;
  assign text_dy  = pix_y - TEXT_Y_V;
  assign text_sel = logo_en_reg ? 2'd0 : (ready_en_reg ? 2'd1 : 2'd2);
  assign text_hit = (logo_en_reg || ready_en_reg || over_en_reg) &&
                    (text_dx[15:6] == '0) && (text_dy[15:8] == '0);

  logic        s1_valid_reg, s1_ground_reg, s1_pipe_reg, s1_bird_reg, s1_digit_reg, s1_text_reg;
  logic [6:0]  s1_ground_addr_reg;
  logic [5:0]  s1_pipe_addr_reg;
  logic [11:0] s1_bird_addr_reg;
  logic [14:0] s1_digit_addr_reg;
  logic [15:0] s1_text_addr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg       <= 1'b0;
      s1_ground_reg      <= 1'b0;
      s1_pipe_reg        <= 1'b0;
      s1_bird_reg        <= 1'b0;
      s1_digit_reg       <= 1'b0;
      s1_text_reg        <= 1'b0;
      s1_ground_addr_reg <= '0;
      s1_pipe_addr_reg   <= '0;
      s1_bird_addr_reg   <= '0;
      s1_digit_addr_reg  <= '0;
      s1_text_addr_reg   <= '0;
    end else begin
      s1_valid_reg       <= pix_valid;
      s1_ground_reg      <= ground_hit;
      s1_pipe_reg        <= |pipe_hit;
      s1_bird_reg        <= bird_hit;
      s1_digit_reg       <= digit_hit;
      s1_text_reg        <= text_hit;
      s1_ground_addr_reg <= ground_addr;
      s1_pipe_addr_reg   <= pipe_sel_addr;
      s1_bird_addr_reg   <= {bird_frame, bird_dy[4:0], bird_dx[4:0]};
      s1_digit_addr_reg  <= {digit_val, num_dy[4:0], num_dx[5:0]};
      s1_text_addr_reg   <= {text_sel, text_dy[7:0], text_dx[5:0]};
    end
  end

  logic [2:0]  layer_next;
  logic [15:0] rom_addr_next;
  always_comb begin
    layer_next    = 3'd0;
    rom_addr_next = '0;
    if (s1_text_reg) begin
      layer_next    = 3'd5;
      rom_addr_next = s1_text_addr_reg;
    end else if (s1_digit_reg) begin
      layer_next    = 3'd4;
      rom_addr_next = {1'b0, s1_digit_addr_reg};
    end else if (s1_bird_reg) begin
      layer_next    = 3'd3;
      rom_addr_next = {4'd0, s1_bird_addr_reg};
    end else if (s1_pipe_reg) begin
      layer_next    = 3'd2;
      rom_addr_next = {10'd0, s1_pipe_addr_reg};
    end else if (s1_ground_reg) begin
      layer_next    = 3'd1;
      rom_addr_next = {9'd0, s1_ground_addr_reg};
    end
  end

  logic        out_valid_reg;
  logic [2:0]  layer_reg;
  logic [15:0] rom_addr_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      layer_reg     <= '0;
      rom_addr_reg  <= '0;
    end else begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        layer_reg    <= layer_next;
        rom_addr_reg <= rom_addr_next;
      end
    end
  end

  assign new_frame = new_frame_reg;
  assign out_valid = out_valid_reg;
  assign layer     = layer_reg;
  assign rom_addr  = rom_addr_reg;

`ifdef PIXEL_COLLIDE_EN
  logic pix_collide_reg;
  // A fresh overlap outranks the frame-start clear so no collision is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_collide_reg <= 1'b0;
    end else if (s1_valid_reg && s1_bird_reg && (s1_pipe_reg || s1_ground_reg)) begin
      pix_collide_reg <= 1'b1;
    end else if (new_frame_reg) begin
      pix_collide_reg <= 1'b0;
    end
  end
  assign pix_collide = pix_collide_reg;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus random traffic, each cycle compared
// against a frame-level behavioural model of the layer/ROM-address rules.
module tb_sprite_compositor;
  logic        clk = 1'b0;
  logic        rst;
  logic        vblank_start, pix_valid;
  logic [15:0] pix_x, pix_y;
  logic [1:0]  bird_status;
  logic [15:0] bird_pos_x, bird_pos_y;
  logic [15:0] pipe1_pos_x, pipe1_pos_y, pipe2_pos_x, pipe2_pos_y, pipe3_pos_x, pipe3_pos_y;
  logic        number_enable;
  logic [15:0] number_pos_x, number_pos_y;
  logic [3:0]  number_num0, number_num1;
  logic        logo_enable, ready_enable, over_enable;
  logic        new_frame, out_valid;
  logic [2:0]  layer;
  logic [15:0] rom_addr;
`ifdef PIXEL_COLLIDE_EN
  logic        pix_collide;
`endif

  sprite_compositor dut (
    .clk(clk), .rst(rst), .vblank_start(vblank_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .bird_status(bird_status),
    .bird_pos_x(bird_pos_x), .bird_pos_y(bird_pos_y),
    .pipe1_pos_x(pipe1_pos_x), .pipe1_pos_y(pipe1_pos_y),
    .pipe2_pos_x(pipe2_pos_x), .pipe2_pos_y(pipe2_pos_y),
    .pipe3_pos_x(pipe3_pos_x), .pipe3_pos_y(pipe3_pos_y),
    .number_enable(number_enable), .number_pos_x(number_pos_x), .number_pos_y(number_pos_y),
    .number_num0(number_num0), .number_num1(number_num1),
    .logo_enable(logo_enable), .ready_enable(ready_enable), .over_enable(over_enable),
    .new_frame(new_frame), .out_valid(out_valid), .layer(layer), .rom_addr(rom_addr)
`ifdef PIXEL_COLLIDE_EN
    , .pix_collide(pix_collide)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model copy of what the frame snapshot should hold.
  int s_bs, s_bx, s_by, s_nx, s_ny, s_n0, s_n1;
  int s_px [3];
  int s_py [3];
  bit s_nen, s_logo, s_ready, s_over;

  bit prev_valid = 0, prev_vb = 0, prev_bird = 0, prev_obst = 0;
  int prev_layer = 0, prev_addr = 0, hold_layer = 0, hold_addr = 0;
  bit exp_coll = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int s16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic bit in_box(input int d, input int size);
    return (d >= 0) && (d < size);
  endfunction

  task automatic capture_shadows();
    s_bs = int'(bird_status);
    s_bx = sx(bird_pos_x);   s_by = sx(bird_pos_y);
    s_px[0] = sx(pipe1_pos_x); s_py[0] = sx(pipe1_pos_y);
    s_px[1] = sx(pipe2_pos_x); s_py[1] = sx(pipe2_pos_y);
    s_px[2] = sx(pipe3_pos_x); s_py[2] = sx(pipe3_pos_y);
    s_nen = number_enable;
    s_nx = sx(number_pos_x); s_ny = sx(number_pos_y);
    s_n0 = int'(number_num0); s_n1 = int'(number_num1);
    s_logo = logo_enable; s_ready = ready_enable; s_over = over_enable;
  endtask

  // Evaluate every layer independently from the snapshot, then pick the top visible one.
  function automatic void model(input int px, input int py, output int lay, output int addr,
                                output bit bird_h, output bit obst_h);
    bit g_h, p_h, d_h, t_h;
    int g_a, p_a, b_a, d_a, t_a, dx, dy, dig, sel, frame;
    g_h = px < 104;
    g_a = (103 - px) & 127;
    p_h = 0; p_a = 0;
    for (int k = 2; k >= 0; k--) begin
      dy = s16(py - s_py[k]);
      if (in_box(dy, 64) && !g_h && ((px < s16(s_px[k] - 240)) || (px >= s_px[k]))) begin
        p_h = 1; p_a = dy;
      end
    end
    dx = s16(px - s_bx); dy = s16(py - s_by);
    bird_h = in_box(dx, 32) && in_box(dy, 32);
    frame  = (s_bs == 3) ? 1 : s_bs;
    b_a    = frame * 1024 + (dy & 31) * 32 + (dx & 31);
    dx = s16(px - s_nx); dy = s16(py - s_ny);
    dig = (dy >= 32) ? s_n0 : s_n1;
    d_h = s_nen && in_box(dx, 48) && in_box(dy, 64) && (dig <= 9);
    d_a = dig * 2048 + (dy & 31) * 64 + dx;
    dx = s16(px - 560); dy = s16(py - 112);
    sel = s_logo ? 0 : (s_ready ? 1 : 2);
    t_h = (s_logo || s_ready || s_over) && in_box(dx, 64) && in_box(dy, 256);
    t_a = sel * 16384 + dy * 64 + dx;
    obst_h = p_h || g_h;
    if (t_h)         begin lay = 5; addr = t_a; end
    else if (d_h)    begin lay = 4; addr = d_a; end
    else if (bird_h) begin lay = 3; addr = b_a; end
    else if (p_h)    begin lay = 2; addr = p_a; end
    else if (g_h)    begin lay = 1; addr = g_a; end
    else             begin lay = 0; addr = 0;   end
  endfunction

  // One clock: predict the pixel on the inputs, advance, compare everything visible now.
  task automatic cycle();
    int lay, addr;
    bit bh, oh, cur_v, cur_vb;
    model(sx(pix_x), sx(pix_y), lay, addr, bh, oh);
    cur_v  = pix_valid;
    cur_vb = vblank_start;
    @(posedge clk);
    #1;
    cyc++;
    if (cur_vb) capture_shadows();
    if (prev_valid) begin
      hold_layer = prev_layer;
      hold_addr  = prev_addr;
    end
    check_val("new_frame", new_frame, cur_vb);
    check_val("out_valid", out_valid, prev_valid);
    check_val("layer", layer, hold_layer);
    check_val("rom_addr", rom_addr, hold_addr);
`ifdef PIXEL_COLLIDE_EN
    if (prev_valid && prev_bird && prev_obst) exp_coll = 1;
    else if (prev_vb) exp_coll = 0;
    check_val("pix_collide", pix_collide, exp_coll);
`endif
    $display("cyc %0d px=%0d py=%0d v=%0b vb=%0b -> nf=%0b ov=%0b layer=%0d addr=0x%0h",
             cyc, sx(pix_x), sx(pix_y), cur_v, cur_vb, new_frame, out_valid, layer, rom_addr);
    prev_valid = cur_v;  prev_vb = cur_vb;
    prev_layer = lay;    prev_addr = addr;
    prev_bird  = bh;     prev_obst = oh;
  endtask

  task automatic drive(input int x, input int y, input bit v, input bit vb);
    pix_x = 16'(x); pix_y = 16'(y); pix_valid = v; vblank_start = vb;
    cycle();
  endtask

  task automatic probe(input int x, input int y, input int el, input int ea);
    drive(x, y, 1, 0);
    drive(0, 0, 0, 0);
    check_val("probe_layer", layer, el);
    check_val("probe_addr", rom_addr, ea);
  endtask

  task automatic latch();
    drive(0, 0, 0, 1);
  endtask

  function automatic logic [15:0] rpos();
    if ($urandom_range(0, 15) == 0) return 16'($urandom);
    return 16'(int'($urandom_range(0, 950)) - 50);
  endfunction

  task automatic randomize_objects();
    bird_status = 2'($urandom_range(0, 3));
    bird_pos_x = rpos(); bird_pos_y = rpos();
    pipe1_pos_x = rpos(); pipe1_pos_y = rpos();
    pipe2_pos_x = rpos(); pipe2_pos_y = rpos();
    pipe3_pos_x = rpos(); pipe3_pos_y = rpos();
    number_enable = 1'($urandom_range(0, 1));
    number_pos_x = rpos(); number_pos_y = rpos();
    number_num0 = 4'($urandom_range(0, 15)); number_num1 = 4'($urandom_range(0, 15));
    logo_enable = 1'($urandom_range(0, 3) == 0);
    ready_enable = 1'($urandom_range(0, 2) == 0);
    over_enable = 1'($urandom_range(0, 2) == 0);
  endtask

  initial begin
    rst = 1; vblank_start = 0; pix_valid = 0; pix_x = '0; pix_y = '0;
    bird_status = '0; bird_pos_x = '0; bird_pos_y = '0;
    pipe1_pos_x = '0; pipe1_pos_y = '0; pipe2_pos_x = '0; pipe2_pos_y = '0;
    pipe3_pos_x = '0; pipe3_pos_y = '0;
    number_enable = 0; number_pos_x = '0; number_pos_y = '0; number_num0 = '0; number_num1 = '0;
    logo_enable = 0; ready_enable = 0; over_enable = 0;
    capture_shadows();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_new_frame", new_frame, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_layer", layer, 0);
    check_val("rst_rom_addr", rom_addr, 0);
    rst = 0;

    // Frame tick alone, then an all-zero snapshot.
    repeat (9) drive(0, 0, 0, 0);
    latch();
    drive(0, 0, 0, 0);
    probe(200, 300, 0, 0);

    // Bird
    bird_pos_x = 16'd400; bird_pos_y = 16'd240; bird_status = 2'd2;
    latch();
    probe(405, 250, 3, 'h945);
    probe(432, 250, 0, 0);

    // Pipe with gap, and the ground strip
    bird_pos_x = 16'd2000; bird_pos_y = 16'd2000;
    pipe1_pos_x = 16'd500; pipe1_pos_y = 16'd100;
    latch();
    probe(200, 130, 2, 30);
    probe(400, 130, 0, 0);
    probe(500, 163, 2, 63);
    probe(500, 164, 0, 0);
    probe(50, 130, 1, 53);

    // Score digits, then a bird underneath them
    number_enable = 1; number_pos_x = 16'd720; number_pos_y = 16'd210;
    number_num1 = 4'd3; number_num0 = 4'd7;
    latch();
    probe(730, 215, 4, 6474);
    probe(730, 250, 4, 14858);
    bird_pos_x = 16'd720; bird_pos_y = 16'd240; bird_status = 2'd0;
    latch();
    probe(730, 250, 4, 14858);

    // Mid-frame input change is invisible until the next snapshot
    number_enable = 0;
    probe(730, 250, 4, 14858);
    drive(730, 250, 1, 1);
    drive(730, 250, 1, 0);
    check_val("vb_same_cycle_layer", layer, 4);
    drive(0, 0, 0, 0);
    check_val("vb_next_layer", layer, 3);
    check_val("vb_next_addr", rom_addr, 330);

    // Text banner with logo outranking over
    logo_enable = 1; over_enable = 1;
    latch();
    probe(570, 120, 5, 522);
    logo_enable = 0; over_enable = 0;

`ifdef PIXEL_COLLIDE_EN
    pipe1_pos_x = 16'd500; pipe1_pos_y = 16'd100;
    bird_pos_x = 16'd200; bird_pos_y = 16'd110; bird_status = 2'd1;
    latch();
    probe(210, 120, 3, 1354);
    check_val("collide_set", pix_collide, 1);
    drive(210, 120, 1, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check_val("collide_set_wins", pix_collide, 1);
    latch();
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check_val("collide_cleared", pix_collide, 0);
`endif

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) randomize_objects();
      if ($urandom_range(0, 15) == 0) begin
        pix_x = 16'($urandom); pix_y = 16'($urandom);
      end else begin
        pix_x = 16'(int'($urandom_range(0, 1000)) - 60);
        pix_y = 16'(int'($urandom_range(0, 1000)) - 60);
      end
      pix_valid    = ($urandom_range(0, 3) != 0);
      vblank_start = ($urandom_range(0, 7) == 0);
      cycle();
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
